// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS core: opcodes, functs, FSM states and ALU operations.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BLT   = 6'b001010;
  localparam logic [5:0] OP_BGT   = 6'b001011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, WRITEBACK} state_t;
  typedef enum logic [1:0] {ADD, SUB, AND, SLT} alu_op_t;

endpackage

// File: rtl/mips_regfile.sv
// Register file: two operand read ports, a debug read port, one synchronous write port; $0 reads zero.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]       rs_data,
  output logic [XLEN-1:0]       rt_data,
  output logic [XLEN-1:0]       dbg_data,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]       wdata
);

  localparam int unsigned NREGS = 1 << REG_ADDR_W;

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i[REG_ADDR_W-1:0]] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rs_data  = (rs_addr  == '0) ? '0 : regs[rs_addr];
  assign rt_data  = (rt_addr  == '0) ? '0 : regs[rt_addr];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: FETCH/DECODE/EXECUTE/WRITEBACK over a req/ack instruction port,
// with branch/jump redirection, a retire pulse and a debug register read port.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     REG_ADDR_W = 5,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [XLEN-1:0]       imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic [XLEN-1:0]       pc,
  output logic [XLEN-1:0]       result,
  output logic                  retire,
  output logic                  illegal,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [XLEN-1:0]       dbg_data
);

  state_t                state, state_next;
  logic [31:0]           ir;
  logic [XLEN-1:0]       a_q, b_q, imm_q, npc_q;
  logic [XLEN-1:0]       rs_data, rt_data, imm_c;
  logic [5:0]            opcode, funct;
  logic [REG_ADDR_W-1:0] rs, rt, rd, dest;
  alu_op_t               alu_op;
  logic                  b_sel_imm, reg_we, load_result, is_jr, is_j, bad_instr;
  logic [XLEN-1:0]       alu_b, alu_out, pc4, br_target, npc_c;
  logic                  br_taken;

  assign opcode    = ir[31:26];
  assign funct     = ir[5:0];
  assign rs        = REG_ADDR_W'(ir[25:21]);
  assign rt        = REG_ADDR_W'(ir[20:16]);
  assign rd        = REG_ADDR_W'(ir[15:11]);
  assign imm_c     = {{(XLEN-16){ir[15]}}, ir[15:0]};
  assign imem_addr = pc;

  mips_regfile #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rs_addr  (rs),
    .rt_addr  (rt),
    .dbg_addr (dbg_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .dbg_data (dbg_data),
    .we       ((state == WRITEBACK) && reg_we && !reset),
    .waddr    (dest),
    .wdata    (result)
  );

  // Instruction decode; IR is stable from DECODE through WRITEBACK.
  always_comb begin
    alu_op      = ADD;
    b_sel_imm   = 1'b0;
    reg_we      = 1'b0;
    load_result = 1'b0;
    is_jr       = 1'b0;
    is_j        = 1'b0;
    bad_instr   = 1'b0;
    dest        = rd;
    case (opcode)
      OP_RTYPE: begin
        reg_we      = 1'b1;
        load_result = 1'b1;
        case (funct)
          FN_ADD: alu_op = ADD;
          FN_SUB: alu_op = SUB;
          FN_AND: alu_op = AND;
          FN_SLT: alu_op = SLT;
          FN_JR: begin
            reg_we      = 1'b0;
            load_result = 1'b0;
            is_jr       = 1'b1;
          end
          default: begin
            reg_we      = 1'b0;
            load_result = 1'b0;
            bad_instr   = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        b_sel_imm   = 1'b1;
        reg_we      = 1'b1;
        load_result = 1'b1;
        dest        = rt;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGT: begin
        alu_op      = SUB;
        load_result = 1'b1;
      end
      OP_J:    is_j = 1'b1;
      default: bad_instr = 1'b1;
    endcase
  end

  // ALU, branch condition and next-pc selection, all evaluated in EXECUTE.
  always_comb begin
    alu_b     = b_sel_imm ? imm_q : b_q;
    pc4       = pc + XLEN'(4);
    br_target = pc4 + (imm_q << 2);
    case (alu_op)
      ADD:     alu_out = a_q + alu_b;
      SUB:     alu_out = a_q - alu_b;
      AND:     alu_out = a_q & alu_b;
      SLT:     alu_out = ($signed(a_q) < $signed(alu_b)) ? XLEN'(1) : '0;
      default: alu_out = '0;
    endcase
    case (opcode)
      OP_BEQ:  br_taken = (a_q == b_q);
      OP_BNE:  br_taken = (a_q != b_q);
      OP_BLT:  br_taken = ($signed(a_q) < $signed(b_q));
      OP_BGT:  br_taken = ($signed(a_q) > $signed(b_q));
      default: br_taken = 1'b0;
    endcase
    npc_c = pc4;
    if (is_jr)         npc_c = a_q;
    else if (is_j)     npc_c = {pc4[XLEN-1:28], ir[25:0], 2'b00};
    else if (br_taken) npc_c = br_target;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  // Handshake and retire pulses are forced low whenever reset is high.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_next = DECODE;
      end
      DECODE:  state_next = EXECUTE;
      EXECUTE: state_next = WRITEBACK;
      WRITEBACK: begin
        retire     = 1'b1;
        illegal    = bad_instr;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
    if (reset) begin
      imem_req = 1'b0;
      retire   = 1'b0;
      illegal  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      npc_q  <= RESET_PC;
      ir     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      imm_q  <= '0;
      result <= '0;
    end else begin
      if ((state == FETCH) && imem_ack) ir <= imem_rdata;
      if (state == DECODE) begin
        a_q   <= rs_data;
        b_q   <= rt_data;
        imm_q <= imm_c;
      end
      if (state == EXECUTE) begin
        npc_q <= npc_c;
        if (load_result) result <= alu_out;
      end
      if (state == WRITEBACK) pc <= npc_q;
    end
  end

endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Parametrised multi-cycle successor to the single-cycle MIPS CPU. It fetches instructions over a req/ack instruction-memory handshake and executes them through an explicit FETCH/DECODE/EXECUTE/WRITEBACK state machine. Branches, jumps and JR really redirect the PC, and register $0 is hardwired to zero. It sits between the instruction memory and the system debug/trace logic, exposing a retire pulse, the current PC and a debug register read port.

## Interface
- XLEN, 32: datapath and register width; legal values 32 or 64.
- REG_ADDR_W, 5: register index width; the register file holds 2**REG_ADDR_W registers.
- RESET_PC, 0: PC value loaded by reset; must be a multiple of 4.

Ports (clock and reset first):
- clk  in  1  the single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  XLEN  fetch address; equals pc, stable while imem_req is high.
- imem_ack  in  1  fetch complete; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- pc  out  XLEN  address of the instruction currently in flight.
- result  out  XLEN  last ALU result (registered).
- retire  out  1  one-cycle pulse per completed instruction.
- illegal  out  1  one-cycle pulse, coincident with retire, for an unknown opcode or funct.
- dbg_addr  in  REG_ADDR_W  debug register index.
- dbg_data  out  XLEN  combinational read of register dbg_addr; $0 always reads 0.

## Operation
- Reset state:
  - pc=RESET_PC, all registers 0, result 0, state FETCH.
  - imem_req, retire and illegal are 0 during any cycle with reset high.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack, latch imem_rdata into IR and go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - A=reg[rs], B=reg[rt], IMM=sign-extended IR[15:0] to XLEN. Go to EXECUTE.
- EXECUTE:
  - Compute the ALU result and the branch condition, and load the result register. Go to WRITEBACK.
- WRITEBACK:
  - Write the register file if the instruction writes and the destination is not 0.
  - Load the next pc, pulse retire, and go to FETCH.
- Instruction set, with pc4 = pc+4:
  - R-type (op 000000), destination rd: ADD 100000 = A+B; SUB 100010 = A−B; AND 100100 = A&B; SLT 101010 = (signed A<B) ? 1 : 0.
  - JR (funct 001000): next pc=A; no register write; result unchanged.
  - ADDI (001000): rt = A+IMM.
  - BEQ (000100) taken if A==B; BNE (000101) if A!=B; BLT (001010) if signed A<B; BGT (001011) if signed A>B.
  - Branch target = pc4 + (IMM<<2). Branches load result with A−B and do not write registers.
  - J (000010): next pc = {pc4[XLEN-1:28], IR[25:0], 2'b00}; result unchanged.
  - Any other opcode or R-type funct: no register write, next pc=pc4, result unchanged, illegal pulses.
- Arithmetic is modulo 2**XLEN with no overflow trap. SLT writes a zero-extended 1 or 0.
- Writes to $0 are discarded.
- A dbg_data read in the WRITEBACK cycle returns the pre-write value.

## Timing
- CPI = 4 + the number of FETCH cycles spent waiting for imem_ack. With ack in the first FETCH cycle, an instruction takes 4 cycles.
- The instruction is latched on the clk edge where imem_req && imem_ack.
- An imem_ack while imem_req is low is ignored.
- retire and illegal are high in the WRITEBACK cycle only.
- pc and the register write take effect on the edge that ends WRITEBACK.
- result updates on the edge that ends EXECUTE.
- Reset asserted in any state, including mid-fetch, takes priority: the next state is FETCH at RESET_PC, in-flight work is abandoned, and no register write occurs. The memory must tolerate an abandoned request.
- Register reads in DECODE always see the previous instruction's write; no hazard logic is needed.

## Structure
- Package mips_pkg holds:
  - opcode and funct localparams;
  - state_t enum (FETCH, DECODE, EXECUTE, WRITEBACK);
  - alu_op_t enum (ADD, SUB, AND, SLT).
- Sub-module mips_regfile: parametrised by XLEN and REG_ADDR_W, with two combinational read ports, a debug read port, one synchronous write port, $0 hardwired to zero, and synchronous reset clearing all entries.
- ALU, decode and FSM are inline in the core.

## Test plan
- Reset, then ADDI $1,$0,5 (0x20010005) with ack in the first FETCH cycle → retire in cycle 4; dbg $1=5, result=5, pc=4.
- With $1=5 and $2=0xFFFFFFFD:
  - ADD $3,$1,$2 → 2;
  - SUB $4,$1,$2 → 8;
  - AND $5,$1,$2 → 5;
  - SLT $6,$2,$1 → 1;
  - SLT $7,$1,$2 → 0.
- Branches:
  - BEQ at pc 0x10 with A=B=7 and imm=3 → pc=0x20;
  - BNE with the same operands → pc=0x14;
  - BLT with A=0xFFFFFFFF, B=1 → taken;
  - BGT with the same operands → not taken.
- Jumps:
  - J with IR[25:0]=0x40 at pc 0x8 → pc=0x100;
  - JR with $6=0x200 → pc=0x200; result unchanged by both.
- Writes to zero and illegal instructions:
  - ADDI $0,$0,9 → dbg $0 reads 0.
  - Opcode 0x3F → illegal and retire pulse together, pc advances by 4, all registers unchanged.
- Fetch stall and reset:
  - imem_ack held low for 3 cycles → imem_req and imem_addr stay stable, retire is delayed by 3 cycles.
  - Reset asserted during the stall → pc=RESET_PC and registers 0 next cycle; the next imem_addr is RESET_PC.
